// File: rtl/mac_share_arb.sv
// Round-robin arbiter sharing one a*b+c datapath between two requesters.
// Each owner streams a, b, c beats; the result returns only to that owner.
module mac_share_arb #(
  parameter int W       = 8,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic         op0_valid,
  input  logic [W-1:0] op0_data,
  input  logic         op1_valid,
  input  logic [W-1:0] op1_data,
  output logic         gnt0,
  output logic         gnt1,
  output logic         res_valid0,
  output logic         res_valid1,
  output logic [W-1:0] res_data,
  output logic         err,
  output logic         busy
);

  typedef enum logic [2:0] {S_IDLE, S_OPA, S_OPB, S_OPC, S_RES} state_e;

  // Abort fires on the idle cycle that would bring the count to TIMEOUT.
  localparam logic [7:0] TO_M1 = 8'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic           owner_q, owner_d;
  logic           ptr_q, ptr_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [7:0]     stall_q, stall_d;
  logic           err_q, err_d;

  logic           op_valid;
  logic [W-1:0]   op_data;
  logic [2*W-1:0] prod, sum;

  // Only the owner's operand lane is ever observed.
  assign op_valid = owner_q ? op1_valid : op0_valid;
  assign op_data  = owner_q ? op1_data  : op0_data;
  assign prod     = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
  assign sum      = prod + {{W{1'b0}}, op_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    stall_d = stall_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_d = (req0 && req1) ? ptr_q : req1;
          stall_d = '0;
          state_d = S_OPA;
        end
      end
      S_OPA, S_OPB, S_OPC: begin
        if (op_valid) begin
          stall_d = '0;
          if (state_q == S_OPA) begin
            a_d     = op_data;
            state_d = S_OPB;
          end else if (state_q == S_OPB) begin
            b_d     = op_data;
            state_d = S_OPC;
          end else begin
            res_d   = sum[W-1:0];
            state_d = S_RES;
          end
        end else if (stall_q == TO_M1) begin
          err_d   = 1'b1;
          stall_d = '0;
          ptr_d   = ~owner_q;
          state_d = S_IDLE;
        end else begin
          stall_d = stall_q + 8'd1;
        end
      end
      S_RES: begin
        ptr_d   = ~owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    res_valid0 = 1'b0;
    res_valid1 = 1'b0;
    if (state_q == S_OPA || state_q == S_OPB || state_q == S_OPC) begin
      gnt0 = ~owner_q;
      gnt1 = owner_q;
    end
    if (state_q == S_RES) begin
      res_valid0 = ~owner_q;
      res_valid1 = owner_q;
    end
    busy     = (state_q != S_IDLE);
    err      = err_q;
    res_data = res_q;
  end

endmodule

// File: tb/tb_mac_share_arb.sv
// Directed bench for mac_share_arb: single ops, wrap, round-robin, stall,
// timeout and async reset, all against hand-computed values.
module tb_mac_share_arb;
  localparam int W = 8;

  logic         clk = 1'b0, rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic         op0_valid = 1'b0, op1_valid = 1'b0;
  logic [W-1:0] op0_data = '0, op1_data = '0;
  logic         gnt0, gnt1, res_valid0, res_valid1, err, busy;
  logic [W-1:0] res_data;

  int n_chk = 0, n_err = 0;

  mac_share_arb #(.W(W), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .op0_valid(op0_valid), .op0_data(op0_data),
    .op1_valid(op1_valid), .op1_data(op1_data),
    .gnt0(gnt0), .gnt1(gnt1), .res_valid0(res_valid0), .res_valid1(res_valid1),
    .res_data(res_data), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Owner lane gets the beat; the other lane carries noise that must be ignored.
  task automatic drive(input bit who, input bit v, input logic [W-1:0] d);
    if (who) begin
      op1_valid = v; op1_data = d; op0_valid = 1'b1; op0_data = 8'hEE;
    end else begin
      op0_valid = v; op0_data = d; op1_valid = 1'b1; op1_data = 8'hEE;
    end
  endtask

  // Entered in an IDLE cycle where 'who' wins the next edge; returns in IDLE.
  task automatic do_op(input bit who, input logic [W-1:0] a, b, c, exp,
                       input int stall, input bit clr);
    step();
    check("gnt_own",   who ? gnt1 : gnt0, 1);
    check("gnt_other", who ? gnt0 : gnt1, 0);
    check("busy_op",   busy, 1);
    if (clr) begin
      if (who) req1 = 1'b0; else req0 = 1'b0;
    end
    drive(who, 1'b1, a); step();
    drive(who, 1'b0, '0);
    for (int i = 0; i < stall; i++) begin
      step();
      check("stall_err", err, 0);
      check("stall_gnt", who ? gnt1 : gnt0, 1);
    end
    drive(who, 1'b1, b); step();
    drive(who, 1'b1, c); step();
    drive(who, 1'b0, '0);
    check("rv_own",   who ? res_valid1 : res_valid0, 1);
    check("rv_other", who ? res_valid0 : res_valid1, 0);
    check("res_data", res_data, exp);
    check("gnt_drop", {gnt1, gnt0}, 0);
    check("res_err",  err, 0);
    step();
    check("rv_clear", {res_valid1, res_valid0}, 0);
    check("busy_idle", busy, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("inv_gnt", gnt0 & gnt1, 0);
      check("inv_pulse", (32'(res_valid0) + 32'(res_valid1) + 32'(err)) > 1, 0);
    end
  end

  initial begin
    #2;
    check("rst_out", {gnt0, gnt1, res_valid0, res_valid1, err, busy}, 0);
    check("rst_data", res_data, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Single op, requester 0: 3*4+5
    req0 = 1'b1;
    do_op(1'b0, 8'd3, 8'd4, 8'd5, 8'd17, 0, 1'b1);

    // Wrap-around, requester 1: 20*20+100 = 500 mod 256
    req1 = 1'b1;
    do_op(1'b1, 8'd20, 8'd20, 8'd100, 8'd244, 0, 1'b1);

    // Round-robin with both held high
    req0 = 1'b1; req1 = 1'b1;
    do_op(1'b0, 8'd2, 8'd3, 8'd1, 8'd7,  0, 1'b0);
    do_op(1'b1, 8'd5, 8'd5, 8'd0, 8'd25, 0, 1'b0);
    do_op(1'b0, 8'd2, 8'd3, 8'd1, 8'd7,  0, 1'b0);
    do_op(1'b1, 8'd5, 8'd5, 8'd0, 8'd25, 0, 1'b0);
    req0 = 1'b0; req1 = 1'b0;

    // 14 idle cycles after a are tolerated: 2*6+1
    req0 = 1'b1;
    do_op(1'b0, 8'd2, 8'd6, 8'd1, 8'd13, 14, 1'b1);

    // Timeout on requester 1 with req0 waiting
    req1 = 1'b1;
    step();
    check("to_gnt1", gnt1, 1);
    req1 = 1'b0; req0 = 1'b1;
    drive(1'b1, 1'b1, 8'd9); step();
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < 14; i++) step();
    check("to_pre_err", err, 0);
    check("to_pre_busy", busy, 1);
    step();
    check("to_err", err, 1);
    check("to_gnt_drop", gnt1, 0);
    check("to_no_rv", res_valid1, 0);
    check("to_busy", busy, 0);
    check("to_res_hold", res_data, 13);
    do_op(1'b0, 8'd1, 8'd1, 8'd1, 8'd2, 0, 1'b1);
    check("to_err_once", err, 0);

    // Async reset mid-operation (in OPB), then contention restarts at r0
    req0 = 1'b1;
    step();
    req0 = 1'b0;
    drive(1'b0, 1'b1, 8'd7); step();
    drive(1'b0, 1'b0, '0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out", {gnt0, gnt1, res_valid0, res_valid1, err, busy}, 0);
    check("mid_rst_data", res_data, 0);
    req0 = 1'b1; req1 = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("rst_hold", {gnt0, gnt1, busy}, 0);
    rst = 1'b0;
    do_op(1'b0, 8'd4, 8'd4, 8'd4, 8'd20, 0, 1'b1);
    do_op(1'b1, 8'd3, 8'd3, 8'd3, 8'd12, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
